// File: rtl/noc_alloc_pkg.sv
// Shared definitions for the NoC output-port allocator: flit-type field width and encodings.
package noc_alloc_pkg;

    localparam int FTYPE_W = 2;

    typedef enum logic [FTYPE_W-1:0] {
        ENC_PAYL = 2'b00,
        ENC_HEAD = 2'b01,
        ENC_TAIL = 2'b10,
        ENC_SING = 2'b11
    } ftype_e;

    // HEAD and SINGLE flits carry a route field and may open an allocation.
    function automatic logic is_route_flit(input logic [FTYPE_W-1:0] ftype);
        return (ftype == ENC_HEAD) || (ftype == ENC_SING);
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational arbiter: scans requests starting at the pointer and returns a one-hot-or-zero grant.
module noc_rr_arbiter #(
    parameter int N_IN  = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_IN-1:0]  req_i,
    input  logic             avail_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_IN-1:0]  grant_o
);

    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // First requester at or after the pointer wins; no grant unless the output is available
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N_IN; k++) begin
            idx_s = PTR_W'((int'(ptr_i) + k) % N_IN);
            if (avail_i && !found_s && req_i[idx_s]) begin
                grant_o[idx_s] = 1'b1;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/noc_allocator_param.sv
// Output-port allocator with wormhole locking and credit flow control.
// Define NOC_ALLOC_RROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module noc_allocator_param
    import noc_alloc_pkg::*;
#(
    parameter int N_IN    = 2,
    parameter int FLIT_W  = 80,
    parameter int PORT_W  = 3,
    parameter int CREDITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORT_W-1:0]        which_port,
    input  logic [N_IN*FLIT_W-1:0]   flit_in,
    input  logic [N_IN-1:0]          valid_in,
    input  logic                     credit_in,
    output logic [N_IN-1:0]          select,
    output logic                     valid_out,
    output logic [N_IN-1:0]          nack_out,
    output logic                     shift_ctl,
    output logic                     credit_err
);

    localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_W = $clog2(CREDITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

    logic [N_IN-1:0]  request_s, is_head_s, is_tail_s;
    logic [N_IN-1:0]  want_s, grant_s, accept_s, sel_s;
    logic [N_IN-1:0]  lock_q, lock_d;
    logic [CNT_W-1:0] credit_cnt_q, credit_cnt_d;
    logic             credit_err_q, credit_err_d;
    logic [PTR_W-1:0] arb_ptr_s;
    logic             locked_s, cred_ok_s, avail_s, fwd_s;
    logic             unused_flit_s;

    // Payload bits above the type and route fields pass through the datapath untouched
    assign unused_flit_s = ^flit_in;

    // Decode flit type and destination port of every valid input
    always_comb begin
        request_s = '0;
        is_head_s = '0;
        is_tail_s = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (valid_in[i]) begin
                is_head_s[i] = (flit_in[i*FLIT_W +: FTYPE_W] == ENC_HEAD);
                is_tail_s[i] = (flit_in[i*FLIT_W +: FTYPE_W] == ENC_TAIL);
                request_s[i] = is_route_flit(flit_in[i*FLIT_W +: FTYPE_W]) &&
                               (flit_in[i*FLIT_W+FTYPE_W +: PORT_W] == which_port);
            end else begin
                is_head_s[i] = 1'b0;
                is_tail_s[i] = 1'b0;
                request_s[i] = 1'b0;
            end
        end
    end

    assign locked_s  = |lock_q;
    assign cred_ok_s = (credit_cnt_q != '0);
    assign avail_s   = ~locked_s & cred_ok_s;

    noc_rr_arbiter #(
        .N_IN  (N_IN),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (request_s),
        .avail_i (avail_s),
        .ptr_i   (arb_ptr_s),
        .grant_o (grant_s)
    );

    assign want_s   = (request_s | lock_q) & valid_in;
    assign accept_s = want_s & (grant_s | lock_q) & {N_IN{cred_ok_s}};
    assign sel_s    = locked_s ? (lock_q & valid_in) : grant_s;
    assign fwd_s    = |accept_s;

    // Outputs are forced low for as long as reset is held
    assign select     = rst ? sel_s : '0;
    assign valid_out  = rst ? fwd_s : 1'b0;
    assign nack_out   = rst ? (want_s & ~accept_s) : '0;
    assign shift_ctl  = rst ? |(grant_s & accept_s) : 1'b0;
    assign credit_err = credit_err_q;

    // A granted HEAD opens the lock; the accepted TAIL of the locked input closes it
    assign lock_d = (lock_q & ~(accept_s & is_tail_s)) | (grant_s & accept_s & is_head_s);

    // Credit counter next state; a return at full saturates and is flagged
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        if (credit_in && (credit_cnt_q == CNT_MAX)) begin
            credit_err_d = 1'b1;
        end else begin
            credit_err_d = credit_err_q;
        end
        case ({credit_in, fwd_s})
            2'b10: begin
                if (credit_cnt_q != CNT_MAX) begin
                    credit_cnt_d = credit_cnt_q + CNT_W'(1);
                end else begin
                    credit_cnt_d = CNT_MAX;
                end
            end
            2'b01:   credit_cnt_d = credit_cnt_q - CNT_W'(1);
            default: credit_cnt_d = credit_cnt_q;
        endcase
    end

    // Lock and credit state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q       <= '0;
            credit_cnt_q <= CNT_MAX;
            credit_err_q <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

`ifdef NOC_ALLOC_RROBIN_EN
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    // Pointer moves just past the granted input and holds otherwise
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < N_IN; i++) begin
            if (grant_s[i]) begin
                rr_ptr_d = (i == N_IN - 1) ? '0 : PTR_W'(i + 1);
            end else begin
                rr_ptr_d = rr_ptr_d;
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign arb_ptr_s = rr_ptr_q;
`else
    assign arb_ptr_s = '0;
`endif

endmodule

// File: tb/tb_noc_allocator_param.sv
// Randomised and directed bench for noc_allocator_param against a packet-level reference model.
module tb_noc_allocator_param;
    import noc_alloc_pkg::*;

    localparam int N  = 4;
    localparam int FW = 16;
    localparam int PW = 3;
    localparam int CR = 2;
    localparam int WP = 2;
`ifdef NOC_ALLOC_RROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [PW-1:0]   which_port = 3'd2;
    logic [N*FW-1:0] flit_in = '0;
    logic [N-1:0]    valid_in = '0;
    logic            credit_in = 1'b0;
    logic [N-1:0]    select, nack_out;
    logic            valid_out, shift_ctl, credit_err;

    always #5 clk = ~clk;

    noc_allocator_param #(.N_IN(N), .FLIT_W(FW), .PORT_W(PW), .CREDITS(CR)) dut (
        .clk(clk), .rst(rst), .which_port(which_port), .flit_in(flit_in),
        .valid_in(valid_in), .credit_in(credit_in), .select(select),
        .valid_out(valid_out), .nack_out(nack_out), .shift_ctl(shift_ctl),
        .credit_err(credit_err)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // reference model state: owning input (-1 none), credits, rr pointer, error flag
    int owner, cnt, ptr;
    bit err;

    logic [1:0] typ [N];
    int         prt [N];
    bit         vin [N];
    bit         cin;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; cnt = CR; ptr = 0; err = 1'b0;
    endtask

    task automatic clear_in();
        for (int i = 0; i < N; i++) begin
            vin[i] = 1'b0; typ[i] = ENC_PAYL; prt[i] = 0;
        end
        cin = 1'b0;
    endtask

    task automatic set_in(input int i, input logic [1:0] t, input int p);
        vin[i] = 1'b1; typ[i] = t; prt[i] = p;
    endtask

    task automatic apply();
        logic [FW-1:0] f;
        for (int i = 0; i < N; i++) begin
            f = FW'($urandom);
            f[1:0] = typ[i];
            f[4:2] = PW'(prt[i]);
            flit_in[i*FW +: FW] = f;
            valid_in[i] = vin[i];
        end
        credit_in = cin;
    endtask

    // Compare current outputs with the model, then advance the model by one clock
    task automatic model_check();
        int gnt = -1;
        int acc = -1;
        logic [N-1:0] e_sel = '0;
        logic [N-1:0] e_nack = '0;
        bit e_shift = 1'b0;
        bit req [N];
        int idx;
        for (int i = 0; i < N; i++)
            req[i] = vin[i] && (typ[i] == ENC_HEAD || typ[i] == ENC_SING) && prt[i] == WP;
        if (owner < 0 && cnt > 0) begin
            for (int k = 0; k < N; k++) begin
                idx = RR ? (ptr + k) % N : k;
                if (gnt < 0 && req[idx]) gnt = idx;
            end
        end
        if (owner >= 0) begin
            if (vin[owner]) e_sel[owner] = 1'b1;
            if (vin[owner] && cnt > 0) acc = owner;
        end else if (gnt >= 0) begin
            e_sel[gnt] = 1'b1;
            acc = gnt;
            e_shift = 1'b1;
        end
        for (int i = 0; i < N; i++)
            if ((req[i] || (i == owner && vin[i])) && i != acc) e_nack[i] = 1'b1;
        check_val("select", 32'(select), 32'(e_sel));
        check_val("valid_out", 32'(valid_out), 32'(acc >= 0));
        check_val("nack_out", 32'(nack_out), 32'(e_nack));
        check_val("shift_ctl", 32'(shift_ctl), 32'(e_shift));
        check_val("credit_err", 32'(credit_err), 32'(err));
        if (acc >= 0) begin
            if (owner == acc && typ[acc] == ENC_TAIL) owner = -1;
            else if (owner < 0 && typ[acc] == ENC_HEAD) owner = acc;
        end
        if (RR && gnt >= 0) ptr = (gnt + 1) % N;
        if (cin && cnt == CR) err = 1'b1;
        if (cin && acc < 0 && cnt < CR) cnt++;
        else if (!cin && acc >= 0) cnt--;
    endtask

    task automatic cycle();
        apply();
        #1;
        model_check();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        clear_in();
        set_in(1, ENC_SING, WP);
        apply();
        #1;
        check_val("rst_select", 32'(select), 32'd0);
        check_val("rst_valid", 32'(valid_out), 32'd0);
        check_val("rst_nack", 32'(nack_out), 32'd0);
        check_val("rst_shift", 32'(shift_ctl), 32'd0);
        check_val("rst_err", 32'(credit_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // two SINGLE streams: alternate under round-robin, input 1 always wins otherwise
        clear_in();
        set_in(1, ENC_SING, WP);
        set_in(3, ENC_SING, WP);
        for (int k = 0; k < 4; k++) begin
            cin = (cnt < CR);
            apply();
            #1;
            if (RR) check_val("rr_alt", 32'(select), (k % 2 == 0) ? 32'h2 : 32'h8);
            else    check_val("fp_win", 32'(select), 32'h2);
            check_val("single_shift", 32'(shift_ctl), 32'd1);
            model_check();
            @(negedge clk);
        end

        // packet from input 0 holds the port; competing HEAD on input 1 waits for the tail
        for (int k = 0; k < 6; k++) begin
            clear_in();
            cin = (cnt < CR);
            if (k < 4) set_in(0, (k == 0) ? ENC_HEAD : ((k == 3) ? ENC_TAIL : ENC_PAYL), (k == 0) ? WP : 5);
            set_in(1, (k < 5) ? ENC_HEAD : ENC_TAIL, WP);
            apply();
            #1;
            if (k < 5) begin
                check_val("pkt_sel", 32'(select), (k < 4) ? 32'h1 : 32'h2);
                check_val("pkt_nack1", 32'(nack_out[1]), (k < 4) ? 32'd1 : 32'd0);
            end
            model_check();
            @(negedge clk);
        end

        // refill credits, then exhaust them with SINGLE flits
        clear_in();
        while (cnt < CR) begin cin = 1'b1; cycle(); end
        clear_in();
        set_in(2, ENC_SING, WP);
        for (int k = 0; k < 3; k++) begin
            apply();
            #1;
            check_val("cred_valid", 32'(valid_out), (k < 2) ? 32'd1 : 32'd0);
            model_check();
            @(negedge clk);
        end
        cin = 1'b1; cycle();
        cin = 1'b0; cycle();
        cin = 1'b1; vin[2] = 1'b0; cycle();
        vin[2] = 1'b1; cycle();
        cin = 1'b0; cycle();
        cycle();
        clear_in();
        while (cnt < CR) begin cin = 1'b1; cycle(); end
        cin = 1'b1; cycle();
        cin = 1'b0; cycle();
        check_val("err_sticky", 32'(credit_err), 32'd1);

        // reset in the middle of a packet
        clear_in();
        set_in(0, ENC_HEAD, WP);
        cycle();
        typ[0] = ENC_PAYL;
        cycle();
        apply();
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_select", 32'(select), 32'd0);
        check_val("arst_valid", 32'(valid_out), 32'd0);
        check_val("arst_err", 32'(credit_err), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(1, ENC_HEAD, WP);
        apply();
        #1;
        check_val("post_rst_grant", 32'(select), 32'h2);
        model_check();
        @(negedge clk);
        clear_in();
        set_in(1, ENC_TAIL, 0);
        cycle();

        // randomised traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                vin[i] = ($urandom_range(9) < 6);
                typ[i] = 2'($urandom_range(3));
                prt[i] = ($urandom_range(1) == 0) ? WP : int'($urandom_range(7));
            end
            cin = (cnt < CR) ? ($urandom_range(9) < 4) : ($urandom_range(99) < 3);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/noc_allocator_param.md
NOC_ALLOCATOR_PARAM -- requirements
Module: noc_allocator_param

Interface
REQ-001 Parameter N_IN, default 2: number of input ports, 2..16.
REQ-002 Parameter FLIT_W, default 80: flit width in bits.
REQ-003 Parameter PORT_W, default 3: width of the output-port field in a head/single flit.
REQ-004 Parameter CREDITS, default 4: downstream buffer depth, 1..15.
REQ-005 clk  in  1: sole clock, all state updates on the rising edge.
REQ-006 rst  in  1: asynchronous, active-low reset.
REQ-007 which_port  in  PORT_W: ID of the output port this allocator serves.
REQ-008 flit_in  in  N_IN*FLIT_W: input flits, slice i = port i.
REQ-009 valid_in  in  N_IN: per-input flit valid.
REQ-010 credit_in  in  1: one downstream slot freed this cycle.
REQ-011 select  out  N_IN: one-hot-or-zero mux select toward the output.
REQ-012 valid_out  out  1: a flit is forwarded this cycle.
REQ-013 nack_out  out  N_IN: input i wants this port but is not accepted this cycle.
REQ-014 shift_ctl  out  1: a head/single is granted this cycle, so trim one route field.
REQ-015 credit_err  out  1: sticky flag, set when credit_in arrives with the counter already at CREDITS.

Function
REQ-016 The flit type SHALL be flit[FTYPE_W-1:0] and the port field flit[FTYPE_W+PORT_W-1:FTYPE_W], both compared only when valid_in[i] is high.
REQ-017 request[i] SHALL be valid & (HEAD|SINGLE) & (port field == which_port).
REQ-018 Arbitration SHALL occur only when avail = (no input locked) & (credit_cnt != 0); at most one grant bit.
REQ-019 Lock register: a granted HEAD SHALL set lock[i] for the next cycle; a granted SINGLE SHALL not lock.
REQ-020 While locked to i, select SHALL be lock & valid_in and new requests SHALL be nacked.
REQ-021 accept[i] SHALL be want[i] & (grant[i] | lock[i]) & (credit_cnt != 0), where want = (request | lock) & valid_in.
REQ-022 valid_out SHALL equal |accept; nack_out SHALL equal want & ~accept.
REQ-023 An accepted TAIL SHALL clear the lock at the next edge; an unaccepted tail SHALL keep it.
REQ-024 credit_cnt SHALL count over 0..CREDITS: -1 on valid_out, +1 on credit_in, unchanged when both occur, saturate at CREDITS when credit_in arrives at full (and set credit_err).
REQ-025 shift_ctl SHALL equal |(grant & accept).
REQ-026 PAYLOAD flits SHALL only be forwarded from the locked input.

Reset
REQ-027 On rst low: lock=0, credit_cnt=CREDITS, rr pointer=0, credit_err=0; select, valid_out, nack_out and shift_ctl SHALL be 0 while reset is asserted.
REQ-028 Reset mid-packet SHALL drop the lock; the open packet is not resumed.

Configuration
REQ-029 Macro NOC_ALLOC_RROBIN_EN defined: round-robin arbitration. The search SHALL start at rr pointer p; after a grant to input i, p SHALL become (i+1) mod N_IN; p SHALL hold when there is no grant.
REQ-030 Macro undefined: fixed priority, lowest index wins, and no pointer register SHALL exist.

Structure
REQ-031 Shared package noc_alloc_pkg SHALL hold FTYPE_W=2 and the encodings ENC_HEAD, ENC_PAYL, ENC_TAIL and ENC_SING.
REQ-032 Arbitration SHALL live in one sub-module, noc_rr_arbiter (request, avail, pointer -> one-hot grant), parameterised by N_IN.

Verification
REQ-033 N_IN=4, RR: inputs 1 and 3 send SINGLE to which_port=2 every cycle -> grants alternate 1,3,1,3 and shift_ctl is high each accepted cycle.
REQ-034 Input 0 sends HEAD, 2 PAYL, TAIL; input 1 sends HEAD in the same cycles -> input 0 gets 4 consecutive accepts, input 1 is nacked until the tail is accepted, then granted.
REQ-035 CREDITS=2, no credit_in, 3 SINGLE flits -> 2 accepted, the third is nacked with valid_out=0; one credit_in pulse -> accepted next cycle.
REQ-036 credit_in together with valid_out at credit_cnt=1 -> counter stays 1; credit_in at credit_cnt=CREDITS -> credit_err=1 until reset.
REQ-037 rst pulsed low while locked mid-packet -> outputs drop to 0 asynchronously; after release, PAYL from the old input is ignored and a new HEAD is granted.
REQ-038 Macro undefined: inputs 0 and 2 request continuously -> input 0 is always granted and input 2 is always nacked.
